// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer
// Purpose  : Sequencing controller for the 3-bit sign-magnitude calculator.
//            Accepts one request at a time, drives normalised operands onto
//            the shared unit bus, waits a fixed settle time, captures the
//            selected unit result and holds it until the consumer takes it.
//            Flags remainder-by-zero and keeps saturating status counters.
// Revision : 1.0 - initial release
// ============================================================================
module calc_op_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [2:0]       req_a,
    input  logic [2:0]       req_b,
    output logic [2:0]       unit_a,
    output logic [2:0]       unit_b,
    output logic [1:0]       unit_op,
    input  logic [4:0]       add_res,
    input  logic [4:0]       sub_res,
    input  logic [4:0]       mul_res,
    input  logic [4:0]       rem_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_result,
    output logic             rsp_dbz,
    output logic [1:0]       rsp_op,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] dbz_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0]       c_settle_load = 4'(SETTLE_CYCLES);
    localparam logic [2:0]       c_neg_zero3   = 3'b100;
    localparam logic [4:0]       c_neg_zero5   = 5'b10000;
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_settle_cnt;

    logic       w_accept;
    logic       w_rsp_hs;
    logic       w_capture;
    logic       w_dbz;
    logic [4:0] w_sel_res;
    logic [4:0] w_cap_res;

    // A new request can be taken when idle, or when the held response leaves
    // on this same edge; reset always blocks acceptance.
    assign req_ready = ~rst & ((r_state == S_IDLE) |
                               ((r_state == S_RESP) & rsp_ready));
    assign w_accept  = req_valid & req_ready;
    assign w_rsp_hs  = (r_state == S_RESP) & rsp_valid & rsp_ready;
    assign w_capture = (r_state == S_SETTLE) & (r_settle_cnt == 4'd1);

    // unit_b is already normalised, so a negative-zero divisor reads as zero.
    assign w_dbz = (unit_op == 2'b11) & (unit_b == 3'b000);

    // Pick the active unit's result and fold negative zero / divide-by-zero to 0.
    always_comb begin
        w_sel_res = add_res;
        case (unit_op)
            2'b00:   w_sel_res = add_res;
            2'b01:   w_sel_res = sub_res;
            2'b10:   w_sel_res = mul_res;
            default: w_sel_res = rem_res;
        endcase
        w_cap_res = w_sel_res;
        if (w_dbz || (w_sel_res == c_neg_zero5)) begin
            w_cap_res = 5'b00000;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_capture) w_next_state = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_hs) w_next_state = w_accept ? S_SETTLE : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Settle timer: loaded on acceptance, counts down while operands settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= 4'd0;
        end else if (w_accept) begin
            r_settle_cnt <= c_settle_load;
        end else if ((r_state == S_SETTLE) && (r_settle_cnt != 4'd0)) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
        end
    end

    // Operand bus: changes only on acceptance, negative zero normalised.
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_a  <= 3'b000;
            unit_b  <= 3'b000;
            unit_op <= 2'b00;
        end else if (w_accept) begin
            unit_a  <= (req_a == c_neg_zero3) ? 3'b000 : req_a;
            unit_b  <= (req_b == c_neg_zero3) ? 3'b000 : req_b;
            unit_op <= req_op;
        end
    end

    // Response register: captured at end of settle, held until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= 5'b00000;
            rsp_dbz    <= 1'b0;
            rsp_op     <= 2'b00;
        end else if (w_capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= w_cap_res;
            rsp_dbz    <= w_dbz;
            rsp_op     <= unit_op;
        end else if (w_rsp_hs) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Saturating completion and divide-by-zero counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt  <= '0;
            dbz_cnt <= '0;
        end else if (w_rsp_hs) begin
            if (op_cnt != c_cnt_max) op_cnt <= op_cnt + 1'b1;
            if (rsp_dbz && (dbz_cnt != c_cnt_max)) dbz_cnt <= dbz_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_op_sequencer
// Purpose  : Self-checking bench for calc_op_sequencer with randomized
//            requests, stub unit results and a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_op_sequencer;

    localparam int S    = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [2:0]    req_a;
    logic [2:0]    req_b;
    logic [2:0]    unit_a;
    logic [2:0]    unit_b;
    logic [1:0]    unit_op;
    logic [4:0]    stub [4];
    logic          rsp_valid;
    logic          rsp_ready;
    logic [4:0]    rsp_result;
    logic          rsp_dbz;
    logic [1:0]    rsp_op;
    logic [CW-1:0] op_cnt;
    logic [CW-1:0] dbz_cnt;

    calc_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .unit_a(unit_a), .unit_b(unit_b), .unit_op(unit_op),
        .add_res(stub[0]), .sub_res(stub[1]), .mul_res(stub[2]), .rem_res(stub[3]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_dbz(rsp_dbz), .rsp_op(rsp_op), .op_cnt(op_cnt), .dbz_cnt(dbz_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction currently owning the operand bus, and its expected response.
    logic [1:0] cur_op;
    logic [2:0] cur_a, cur_b;
    logic [4:0] exp_res;
    logic       exp_dbz;
    int         m_ops, m_dbz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] norm3(input logic [2:0] x);
        return (x == 3'b100) ? 3'b000 : x;
    endfunction

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    function automatic logic [2:0] rand_opnd();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000;
        return 3'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_stubs();
        for (int i = 0; i < 4; i++)
            stub[i] = ($urandom_range(0, 3) == 0) ? 5'b10000 : 5'($urandom);
    endtask

    task automatic check_units(input string tag);
        check_eq({tag, "_ua"}, unit_a, norm3(cur_a));
        check_eq({tag, "_ub"}, unit_b, norm3(cur_b));
        check_eq({tag, "_uop"}, unit_op, cur_op);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        req_valid = 1'b1;
        req_op = 2'($urandom);
        req_a = 3'($urandom);
        req_b = 3'($urandom);
        rsp_ready = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            #1;
            check_eq("rst_req_ready", req_ready, 0);
            tick();
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_outs", {unit_a, unit_b, unit_op, rsp_result, rsp_dbz, rsp_op}, 0);
            check_eq("rst_cnts", {op_cnt, dbz_cnt}, 0);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check_eq("rel_req_ready", req_ready, 1);
        m_ops = 0;
        m_dbz = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        int n;
        n = 0;
        cur_op = op; cur_a = a; cur_b = b;
        req_op = op; req_a = a; req_b = b;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            check_eq("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        req_op = 2'($urandom); req_a = 3'($urandom); req_b = 3'($urandom);
        check_units("accept");
    endtask

    task automatic wait_rsp();
        int n;
        logic [4:0] sel;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("latency", n, S);
        exp_dbz = (cur_op == 2'b11) && (norm3(cur_b) == 3'b000);
        sel = stub[cur_op];
        exp_res = (exp_dbz || sel == 5'b10000) ? 5'b00000 : sel;
        check_eq("rsp_result", rsp_result, exp_res);
        check_eq("rsp_dbz", rsp_dbz, exp_dbz);
        check_eq("rsp_op", rsp_op, cur_op);
        check_units("settle");
    endtask

    task automatic finish_rsp(input int stall, input bit handoff);
        logic [1:0] nop;
        logic [2:0] na, nb;
        rsp_ready = 1'b0;
        nop = 2'($urandom); na = rand_opnd(); nb = rand_opnd();
        if (handoff) begin
            rand_stubs();
            req_op = nop; req_a = na; req_b = nb;
            req_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < stall; i++) begin
            check_eq("stall_req_ready", req_ready, 0);
            tick();
            check_eq("stall_valid", rsp_valid, 1);
            check_eq("stall_rsp", {rsp_result, rsp_dbz, rsp_op}, {exp_res, exp_dbz, cur_op});
            check_units("stall");
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("hs_req_ready", req_ready, 1);
        tick();
        m_ops++;
        if (exp_dbz) m_dbz++;
        check_eq("op_cnt", op_cnt, sat(m_ops));
        check_eq("dbz_cnt", dbz_cnt, sat(m_dbz));
        check_eq("hs_valid_drop", rsp_valid, 0);
        rsp_ready = 1'b0;
        if (handoff) begin
            cur_op = nop; cur_a = na; cur_b = nb;
            req_valid = 1'b0;
            check_units("handoff");
        end
    endtask

    initial begin
        bit pending;
        int accs[$];
        int c, done;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        rand_stubs();
        cur_op = '0; cur_a = '0; cur_b = '0; exp_res = '0; exp_dbz = 1'b0;
        m_ops = 0; m_dbz = 0;
        tick();

        // Reset held two cycles with a request pending.
        apply_reset(2);

        // Remainder with nonzero divisor.
        rand_stubs();
        stub[3] = 5'b00001;
        send(2'b11, 3'b011, 3'b010);
        wait_rsp();
        check_eq("rem_result", rsp_result, 5'b00001);
        finish_rsp(0, 0);

        // Negative-zero divisor.
        apply_reset(1);
        rand_stubs();
        stub[3] = 5'b10011;
        send(2'b11, 3'b111, 3'b100);
        check_eq("nz_unit_b", unit_b, 3'b000);
        wait_rsp();
        check_eq("nz_dbz", rsp_dbz, 1);
        check_eq("nz_result", rsp_result, 0);
        finish_rsp(0, 0);
        check_eq("nz_dbz_cnt", dbz_cnt, 1);

        // Backpressure with a second request waiting, same-edge handoff.
        rand_stubs();
        send(2'($urandom), rand_opnd(), rand_opnd());
        wait_rsp();
        finish_rsp(5, 1);
        wait_rsp();
        finish_rsp(0, 0);

        // Reset during SETTLE discards the operation and clears counters.
        rand_stubs();
        send(2'b00, 3'b001, 3'b010);
        rst = 1'b1;
        tick();
        check_eq("midrst_valid", rsp_valid, 0);
        check_eq("midrst_cnt", {op_cnt, dbz_cnt}, 0);
        check_eq("midrst_unit", {unit_a, unit_b, unit_op}, 0);
        rst = 1'b0;
        #1;
        check_eq("midrst_idle", req_ready, 1);
        for (int i = 0; i < S + 3; i++) begin
            tick();
            check_eq("midrst_no_rsp", rsp_valid, 0);
        end
        m_ops = 0; m_dbz = 0;

        // Reset in RESP beats a simultaneous response and request handshake.
        rand_stubs();
        send(2'b11, 3'b010, 3'b000);
        wait_rsp();
        rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1;
        req_op = 2'b01; req_a = 3'b011; req_b = 3'b001;
        tick();
        check_eq("resprst_valid", rsp_valid, 0);
        check_eq("resprst_rsp", {rsp_result, rsp_dbz, rsp_op}, 0);
        check_eq("resprst_cnt", {op_cnt, dbz_cnt}, 0);
        check_eq("resprst_unit", {unit_a, unit_b, unit_op}, 0);
        apply_reset(1);

        // Back-to-back adds with rsp_ready high: spacing and saturation.
        rand_stubs();
        rsp_ready = 1'b1; req_valid = 1'b1;
        req_op = 2'b00; req_a = 3'b001; req_b = 3'b011;
        c = 0; done = 0;
        while (done < 5 && c < 60) begin
            logic acc, cmp;
            acc = req_valid && req_ready;
            cmp = rsp_valid && rsp_ready;
            tick();
            c++;
            if (acc) begin
                accs.push_back(c);
                if (accs.size() == 5) req_valid = 1'b0;
            end
            if (cmp) begin
                done++;
                check_eq("sat_op_cnt", op_cnt, sat(done));
            end
        end
        if (done < 5) check_eq("b2b_timeout", done, 5);
        for (int i = 1; i < accs.size(); i++)
            check_eq("b2b_spacing", accs[i] - accs[i-1], S + 1);
        rsp_ready = 1'b0; req_valid = 1'b0;
        m_ops = done; m_dbz = 0;
        tick();

        // Randomized traffic with stalls and handoffs.
        pending = 1'b0;
        for (int t = 0; t < 120; t++) begin
            if (t % 20 == 0 && !pending) apply_reset(1);
            if (!pending) begin
                rand_stubs();
                send(2'($urandom), rand_opnd(), rand_opnd());
                wait_rsp();
            end
            pending = 1'($urandom);
            finish_rsp($urandom_range(0, 3), pending);
            if (pending) wait_rsp();
        end
        if (pending) finish_rsp(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Sequencing controller for the 3-bit sign-magnitude calculator datapath. It accepts one operation request at a time over a valid/ready handshake and registers the normalised operands onto the shared operand bus of the add/sub/mul/rem units. It waits a fixed settle time, then captures the selected unit's 5-bit result. The response is held until the consumer accepts it. The block also detects divide-by-zero for remainder operations and keeps saturating completion and divide-by-zero counters.

## Interface
- SETTLE_CYCLES, 2, cycles the operands are held on the unit bus before capture; legal range 1..15
- CNT_W, 8, width of the status counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where req_valid & req_ready
- req_op  in  2  operation: 00 add, 01 sub, 10 mul, 11 rem
- req_a, req_b  in  3  sign-magnitude operands: bit2 sign, bits1:0 magnitude
- unit_a, unit_b  out  3  registered, normalised operands driven to all units
- unit_op  out  2  registered op, selects the active unit
- add_res, sub_res, mul_res, rem_res  in  5  unit results: bit4 sign, bits3:0 magnitude
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts on an edge where rsp_valid & rsp_ready
- rsp_result  out  5  captured result
- rsp_dbz  out  1  divide-by-zero flag for this response
- rsp_op  out  2  op of this response
- op_cnt  out  CNT_W  completed responses, saturating
- dbz_cnt  out  CNT_W  completed responses with rsp_dbz=1, saturating

## Operation
- The FSM has three states: IDLE, SETTLE and RESP.
- req_ready is combinational: (state==IDLE) | (state==RESP & rsp_ready), forced to 0 while rst=1.
- **IDLE, on acceptance:**
  - Register unit_a, unit_b and unit_op, with negative zero (3'b100) normalised to 3'b000.
  - Load settle_cnt = SETTLE_CYCLES and go to SETTLE.
- **SETTLE:**
  - settle_cnt decrements each cycle.
  - On the edge where settle_cnt==1, capture into rsp_result the result selected by unit_op, set rsp_op and rsp_dbz, set rsp_valid=1 and go to RESP.
- **Divide-by-zero:** rsp_dbz=1 iff unit_op==11 and unit_b==000.
  - When rsp_dbz=1, rsp_result is forced to 5'b00000 and rem_res is ignored.
- **Result normalisation:** a captured 5'b10000 is stored as 5'b00000.
- **RESP:**
  - rsp_* is held stable while rsp_ready=0.
  - On rsp handshake, op_cnt increments, and dbz_cnt also increments if rsp_dbz=1.
  - If req_valid is also high on that edge, the new request is accepted on the same edge. unit_* updates, rsp_valid drops and the state goes to SETTLE.
  - Otherwise rsp_valid drops and the state goes to IDLE.
- unit_a, unit_b and unit_op change only on acceptance edges and are stable through SETTLE and RESP.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Request inputs are ignored when no handshake occurs.

## Timing
- **Reset values:** state IDLE, req_ready=0 during rst, rsp_valid=0, rsp_result=0, rsp_dbz=0, rsp_op=0, unit_a=unit_b=unit_op=0, op_cnt=dbz_cnt=0.
- **After rst:** req_ready=1 in the first cycle after rst deasserts.
- **Latency:** acceptance on edge E0 gives rsp_valid=1 after edge E0+SETTLE_CYCLES.
- **Throughput:** with rsp_ready tied high, one request every SETTLE_CYCLES+1 cycles.
- **rst in SETTLE or RESP:** the in-flight operation and any pending response are discarded and counters are cleared. rsp_valid is 0 after the reset edge.
- rst has priority over any simultaneous handshake.
- **Same-edge handshakes in RESP:** response completion and new-request acceptance on one edge are both honoured. Counters update for the completed response. The new response appears SETTLE_CYCLES later.
- **Unit timing:** the units are combinational. Results are sampled only on the capture edge.

## Test plan
- **Reset:**
  - Stimulus: hold rst for 2 cycles with req_valid=1.
  - Required: req_ready=0 and rsp_valid=0 during reset, no acceptance, all outputs 0; req_ready=1 on the first cycle after release.
- **Remainder op:**
  - Stimulus: SETTLE_CYCLES=2; request op=11, a=3'b011, b=3'b010; stub rem_res=5'b00001.
  - Required: unit_a=011 and unit_b=010 after acceptance; rsp_valid rises exactly 2 cycles after acceptance; rsp_result=00001, rsp_dbz=0, rsp_op=11.
- **Negative-zero divisor:**
  - Stimulus: op=11, a=3'b111, b=3'b100; stub rem_res=5'b10011.
  - Required: unit_b=000, rsp_dbz=1, rsp_result=00000; after the handshake, dbz_cnt=1 and op_cnt=1.
- **Backpressure and same-edge handoff:**
  - Stimulus: hold rsp_ready=0 for 5 cycles with a second request pending; then raise rsp_ready.
  - Required: rsp_* stable and req_ready=0 throughout the stall; the second request is accepted on the same edge as the response handshake; unit_* updates on that edge.
- **Back-to-back and saturation:**
  - Stimulus: CNT_W=2, rsp_ready=1, 5 consecutive add requests.
  - Required: acceptances are spaced SETTLE_CYCLES+1 cycles apart; op_cnt reads 1, 2, 3, 3, 3.
- **Reset mid-operation:**
  - Stimulus: assert rst during SETTLE.
  - Required: next cycle state is IDLE, rsp_valid never asserts for that op, and op_cnt=0.
